oflow_calc_iou: RTL and testbench

Computes the Intersection-over-Union of two axis-aligned bounding boxes: the current frame box and a history box. It is a multi-cycle engine. Each computation is launched by a single-cycle start pulse, and completion is reported with a one-cycle valid_iou pulse. It sits inside oflow_similarity_metric, which weights the IoU together with the size, colour and history distances.

---
 rtl/oflow_iou_pkg.sv | 50 +++++
 rtl/oflow_iou_divider.sv | 72 +++++++
 rtl/oflow_calc_iou.sv | 140 ++++++++++++++
 tb/tb_oflow_calc_iou.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_iou_pkg.sv
// Shared definitions for the IoU engine: field widths, packed-box slice
// positions, FSM state encoding and the 1-D overlap helper.
package oflow_iou_pkg;

    localparam int COORD_LEN            = 11;
    localparam int POSITION_CONCATE_LEN = 4 * COORD_LEN;
    localparam int WIDTH_LEN            = 8;
    localparam int HEIGHT_LEN           = 8;
    localparam int IOU_LEN              = 22;

    // Derived widths: one box area, the sum of two areas, and the raw overlap
    // product of two coordinate spans.
    localparam int AREA_LEN  = WIDTH_LEN + HEIGHT_LEN;
    localparam int UNION_LEN = AREA_LEN + 1;
    localparam int INTER_LEN = 2 * COORD_LEN;

    // Slice positions inside a packed box {X_TL, Y_TL, X_BR, Y_BR}.
    localparam int X_TL_MSB = 4 * COORD_LEN - 1;
    localparam int X_TL_LSB = 3 * COORD_LEN;
    localparam int Y_TL_MSB = 3 * COORD_LEN - 1;
    localparam int Y_TL_LSB = 2 * COORD_LEN;
    localparam int X_BR_MSB = 2 * COORD_LEN - 1;
    localparam int X_BR_LSB = 1 * COORD_LEN;
    localparam int Y_BR_MSB = 1 * COORD_LEN - 1;
    localparam int Y_BR_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        INTER,
        UNION,
        DIV,
        DONE
    } iou_state_t;

    // Overlap of two half-open intervals [tl, br); zero when they only touch
    // or are disjoint.
    function automatic logic [COORD_LEN-1:0] overlap_len(
        input logic [COORD_LEN-1:0] tl_a,
        input logic [COORD_LEN-1:0] br_a,
        input logic [COORD_LEN-1:0] tl_b,
        input logic [COORD_LEN-1:0] br_b
    );
        logic [COORD_LEN-1:0] lo;
        logic [COORD_LEN-1:0] hi;
        lo = (tl_a > tl_b) ? tl_a : tl_b;
        hi = (br_a < br_b) ? br_a : br_b;
        return (hi > lo) ? (hi - lo) : '0;
    endfunction

endpackage

// File: rtl/oflow_iou_divider.sv
// Sequential restoring divider producing the fractional quotient
// floor(num * 2^Q_LEN / den), one bit per cycle. The caller guarantees
// num < den, so the remainder always fits in D_LEN bits. The first quotient
// bit is resolved on the load edge, so o_done rises Q_LEN-1 edges after
// i_start and stays high for one cycle.
module oflow_iou_divider #(
    parameter int Q_LEN = 22,
    parameter int D_LEN = 17
) (
    input  logic             clk,
    input  logic             reset_N,
    input  logic             i_start,
    input  logic [D_LEN-1:0] i_num,
    input  logic [D_LEN-1:0] i_den,
    output logic             o_done,
    output logic [Q_LEN-1:0] o_quot
);

    localparam int CNT_LEN = $clog2(Q_LEN);

    logic [D_LEN-1:0]   r_rem;
    logic [D_LEN-1:0]   r_den;
    logic [Q_LEN-1:0]   r_quot;
    logic [CNT_LEN-1:0] r_cnt;
    logic               r_busy;

    logic [D_LEN-1:0]   w_den;
    logic [D_LEN:0]     w_shift;
    logic               w_bit;
    logic [D_LEN-1:0]   w_rem_next;

    // One restoring step: double the remainder, subtract the divisor if it fits.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, otherwise
        // synthesis would infer a latch to hold the missing case.
        w_den      = i_start ? i_den : r_den;
        w_shift    = {(i_start ? i_num : r_rem), 1'b0};
        w_bit      = (w_shift >= {1'b0, w_den});
        w_rem_next = w_bit ? D_LEN'(w_shift - {1'b0, w_den}) : D_LEN'(w_shift);
    end

    // Load on start (resolving the first bit), then shift in one bit per cycle.
    always_ff @(posedge clk or negedge reset_N) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset_N) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_den  <= i_den;
            r_rem  <= w_rem_next;
            r_quot <= {{(Q_LEN-1){1'b0}}, w_bit};
            r_cnt  <= CNT_LEN'(Q_LEN - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                r_rem  <= w_rem_next;
                r_quot <= {r_quot[Q_LEN-2:0], w_bit};
                r_cnt  <= r_cnt - 1'b1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done = r_busy && (r_cnt == '0);
    assign o_quot = r_quot;

endmodule

// File: rtl/oflow_calc_iou.sv
// Intersection-over-Union of the current-frame box and a history box.
// Fixed 25-cycle engine: INTER, UNION, 22 DIV cycles, then a one-cycle DONE
// that pulses valid_iou with the q0.22 result held on iou.
module oflow_calc_iou
    import oflow_iou_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset_N,
    input  logic                            start,
    input  logic [POSITION_CONCATE_LEN-1:0] bbox_position_frame_k,
    input  logic [POSITION_CONCATE_LEN-1:0] bbox_position_frame_history,
    input  logic [WIDTH_LEN-1:0]            bbox_w_frame_k,
    input  logic [HEIGHT_LEN-1:0]           bbox_h_frame_k,
    input  logic [WIDTH_LEN-1:0]            bbox_w_frame_history,
    input  logic [HEIGHT_LEN-1:0]           bbox_h_frame_history,
    output logic                            valid_iou,
    output logic [IOU_LEN-1:0]              iou
);

    iou_state_t r_state;
    iou_state_t w_next_state;

    logic [POSITION_CONCATE_LEN-1:0] r_box_k;
    logic [POSITION_CONCATE_LEN-1:0] r_box_h;
    logic [WIDTH_LEN-1:0]            r_w_k;
    logic [HEIGHT_LEN-1:0]           r_h_k;
    logic [WIDTH_LEN-1:0]            r_w_h;
    logic [HEIGHT_LEN-1:0]           r_h_h;

    logic [INTER_LEN-1:0] r_inter;
    logic                 r_force_zero;
    logic                 r_force_sat;
    logic [IOU_LEN-1:0]   r_iou;

    logic [COORD_LEN-1:0] w_ox;
    logic [COORD_LEN-1:0] w_oy;
    logic [INTER_LEN-1:0] w_inter;
    logic [UNION_LEN-1:0] w_union;
    logic                 w_zero;
    logic                 w_sat;

    logic                 w_div_start;
    logic [UNION_LEN-1:0] w_div_num;
    logic [UNION_LEN-1:0] w_div_den;
    logic                 w_div_done;
    logic [IOU_LEN-1:0]   w_div_quot;

    // Overlap and union arithmetic on the captured boxes.
    always_comb begin
        w_ox = overlap_len(r_box_k[X_TL_MSB:X_TL_LSB], r_box_k[X_BR_MSB:X_BR_LSB],
                           r_box_h[X_TL_MSB:X_TL_LSB], r_box_h[X_BR_MSB:X_BR_LSB]);
        w_oy = overlap_len(r_box_k[Y_TL_MSB:Y_TL_LSB], r_box_k[Y_BR_MSB:Y_BR_LSB],
                           r_box_h[Y_TL_MSB:Y_TL_LSB], r_box_h[Y_BR_MSB:Y_BR_LSB]);
        w_inter = INTER_LEN'(w_ox) * INTER_LEN'(w_oy);
        // Union wraps at 17 bits; subtracting the truncated overlap is exact mod 2^17.
        w_union = UNION_LEN'(r_w_k) * UNION_LEN'(r_h_k)
                + UNION_LEN'(r_w_h) * UNION_LEN'(r_h_h)
                - r_inter[UNION_LEN-1:0];
        w_zero  = (w_union == '0) || (r_inter == '0);
        w_sat   = (r_inter >= INTER_LEN'(w_union));
        // Special cases still run the divider on a harmless 0/1 so latency stays fixed.
        w_div_start = (r_state == UNION);
        w_div_num   = (w_zero || w_sat) ? '0 : r_inter[UNION_LEN-1:0];
        w_div_den   = (w_zero || w_sat) ? UNION_LEN'(1) : w_union;
    end

    oflow_iou_divider #(
        .Q_LEN (IOU_LEN),
        .D_LEN (UNION_LEN)
    ) u_divider (
        .clk     (clk),
        .reset_N (reset_N),
        .i_start (w_div_start),
        .i_num   (w_div_num),
        .i_den   (w_div_den),
        .o_done  (w_div_done),
        .o_quot  (w_div_quot)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next_state = INTER;
            INTER:   w_next_state = UNION;
            UNION:   w_next_state = DIV;
            DIV:     if (w_div_done) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: capture inputs, latch overlap, classify, and load the result.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_box_k      <= '0;
            r_box_h      <= '0;
            r_w_k        <= '0;
            r_h_k        <= '0;
            r_w_h        <= '0;
            r_h_h        <= '0;
            r_inter      <= '0;
            r_force_zero <= 1'b0;
            r_force_sat  <= 1'b0;
            r_iou        <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_box_k <= bbox_position_frame_k;
                r_box_h <= bbox_position_frame_history;
                r_w_k   <= bbox_w_frame_k;
                r_h_k   <= bbox_h_frame_k;
                r_w_h   <= bbox_w_frame_history;
                r_h_h   <= bbox_h_frame_history;
            end
            if (r_state == INTER) begin
                r_inter <= w_inter;
            end
            if (r_state == UNION) begin
                r_force_zero <= w_zero;
                r_force_sat  <= w_sat;
            end
            if (r_state == DIV && w_div_done) begin
                r_iou <= r_force_zero ? '0 : (r_force_sat ? '1 : w_div_quot);
            end
        end
    end

    assign valid_iou = (r_state == DONE);
    assign iou       = r_iou;

endmodule

// File: tb/tb_oflow_calc_iou.sv
// Scoreboard bench for oflow_calc_iou: the driver pushes the expected IoU and
// launch cycle for every accepted start; an independent monitor pops and
// compares on each valid_iou pulse, also checking latency and hold behaviour.
module tb_oflow_calc_iou;
    import oflow_iou_pkg::*;

    localparam int CLK_HALF = 5;

    logic                            clk = 1'b0;
    logic                            reset_N;
    logic                            start;
    logic [POSITION_CONCATE_LEN-1:0] bbox_position_frame_k;
    logic [POSITION_CONCATE_LEN-1:0] bbox_position_frame_history;
    logic [WIDTH_LEN-1:0]            bbox_w_frame_k;
    logic [HEIGHT_LEN-1:0]           bbox_h_frame_k;
    logic [WIDTH_LEN-1:0]            bbox_w_frame_history;
    logic [HEIGHT_LEN-1:0]           bbox_h_frame_history;
    logic                            valid_iou;
    logic [IOU_LEN-1:0]              iou;

    oflow_calc_iou dut (
        .clk                         (clk),
        .reset_N                     (reset_N),
        .start                       (start),
        .bbox_position_frame_k       (bbox_position_frame_k),
        .bbox_position_frame_history (bbox_position_frame_history),
        .bbox_w_frame_k              (bbox_w_frame_k),
        .bbox_h_frame_k              (bbox_h_frame_k),
        .bbox_w_frame_history        (bbox_w_frame_history),
        .bbox_h_frame_history        (bbox_h_frame_history),
        .valid_iou                   (valid_iou),
        .iou                         (iou)
    );

    always #CLK_HALF clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [IOU_LEN-1:0] iou;
        int                 cyc;
        string              name;
    } exp_t;

    exp_t               sb[$];
    exp_t               mon_e;
    int                 n_tests = 0;
    int                 n_fail  = 0;
    bit                 hold_pend = 1'b0;
    logic [IOU_LEN-1:0] hold_val;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference: IoU from the arithmetic definition, with 17-bit union wrap.
    function automatic logic [IOU_LEN-1:0] model_iou(
        input int kx0, input int ky0, input int kx1, input int ky1,
        input int hx0, input int hy0, input int hx1, input int hy1,
        input int wk, input int hk, input int wh, input int hh
    );
        longint ox, oy, inter, uni;
        ox = imin(kx1, hx1) - imax(kx0, hx0);
        oy = imin(ky1, hy1) - imax(ky0, hy0);
        if (ox < 0) ox = 0;
        if (oy < 0) oy = 0;
        inter = ox * oy;
        uni   = (longint'(wk) * hk + longint'(wh) * hh - inter) & 64'h1FFFF;
        if (uni == 0 || inter == 0) return '0;
        if (inter >= uni)           return {IOU_LEN{1'b1}};
        return IOU_LEN'((inter << IOU_LEN) / uni);
    endfunction

    function automatic logic [POSITION_CONCATE_LEN-1:0] pack_box(
        input int x0, input int y0, input int x1, input int y1
    );
        return {COORD_LEN'(x0), COORD_LEN'(y0), COORD_LEN'(x1), COORD_LEN'(y1)};
    endfunction

    // Issue one start pulse; optionally register the expected result.
    task automatic do_op(
        input string name,
        input int kx0, input int ky0, input int kx1, input int ky1,
        input int hx0, input int hy0, input int hx1, input int hy1,
        input int wk, input int hk, input int wh, input int hh,
        input bit push = 1'b1
    );
        exp_t e;
        @(negedge clk);
        bbox_position_frame_k       = pack_box(kx0, ky0, kx1, ky1);
        bbox_position_frame_history = pack_box(hx0, hy0, hx1, hy1);
        bbox_w_frame_k              = WIDTH_LEN'(wk);
        bbox_h_frame_k              = HEIGHT_LEN'(hk);
        bbox_w_frame_history        = WIDTH_LEN'(wh);
        bbox_h_frame_history        = HEIGHT_LEN'(hh);
        start                       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Inputs are free to change once captured.
        bbox_position_frame_k       = POSITION_CONCATE_LEN'({$urandom(), $urandom()});
        bbox_position_frame_history = POSITION_CONCATE_LEN'({$urandom(), $urandom()});
        bbox_w_frame_k              = WIDTH_LEN'($urandom());
        bbox_h_frame_k              = HEIGHT_LEN'($urandom());
        bbox_w_frame_history        = WIDTH_LEN'($urandom());
        bbox_h_frame_history        = HEIGHT_LEN'($urandom());
        if (push) begin
            e.iou  = model_iou(kx0, ky0, kx1, ky1, hx0, hy0, hx1, hy1, wk, hk, wh, hh);
            e.cyc  = cyc;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    // Monitor: compare each valid_iou pulse against the scoreboard head.
    always @(negedge clk) begin
        if (reset_N !== 1'b1) begin
            hold_pend = 1'b0;
        end else if (valid_iou === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid_iou=1 at cycle %0d, expected 0 (nothing pending)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_iou"}, 32'(iou), 32'(mon_e.iou));
                check({mon_e.name, "_latency"}, cyc - mon_e.cyc, 24);
                hold_pend = 1'b1;
                hold_val  = mon_e.iou;
            end
        end else if (hold_pend) begin
            check("iou_hold_after_done", 32'(iou), 32'(hold_val));
            hold_pend = 1'b0;
        end
    end

    initial begin
        #(100000 * 2 * CLK_HALF);
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kx0, ky0, kx1, ky1, hx0, hy0, hx1, hy1, wk, hk, wh, hh;

        reset_N                     = 1'b0;
        start                       = 1'b0;
        bbox_position_frame_k       = '0;
        bbox_position_frame_history = '0;
        bbox_w_frame_k              = '0;
        bbox_h_frame_k              = '0;
        bbox_w_frame_history        = '0;
        bbox_h_frame_history        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(valid_iou), 32'd0);
        check("reset_iou", 32'(iou), 32'd0);
        @(negedge clk);
        reset_N = 1'b1;

        // Directed cases.
        do_op("identical", 10, 10, 20, 20, 10, 10, 20, 20, 10, 10, 10, 10);
        repeat (25) @(posedge clk);
        do_op("disjoint", 0, 0, 10, 10, 20, 20, 30, 30, 10, 10, 10, 10);
        repeat (25) @(posedge clk);
        do_op("half_overlap", 0, 0, 10, 10, 5, 0, 15, 10, 10, 10, 10, 10);
        repeat (25) @(posedge clk);
        do_op("edge_touch", 0, 0, 10, 10, 10, 0, 20, 10, 10, 10, 10, 10);
        repeat (25) @(posedge clk);
        do_op("zero_area", 5, 5, 5, 5, 5, 5, 5, 5, 0, 0, 0, 0);
        repeat (25) @(posedge clk);

        // A second start mid-operation must be ignored.
        do_op("restart_ignored", 0, 0, 10, 10, 5, 0, 15, 10, 10, 10, 10, 10);
        repeat (4) @(posedge clk);
        do_op("ignored_start", 10, 10, 20, 20, 10, 10, 20, 20, 10, 10, 10, 10, 1'b0);
        repeat (50) @(posedge clk);

        // Reset mid-operation aborts without a result.
        do_op("aborted", 10, 10, 20, 20, 10, 10, 20, 20, 10, 10, 10, 10, 1'b0);
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset_N = 1'b0;
        #1;
        check("abort_valid", 32'(valid_iou), 32'd0);
        check("abort_iou", 32'(iou), 32'd0);
        repeat (2) @(negedge clk);
        reset_N = 1'b1;
        repeat (30) @(posedge clk);
        check("abort_iou_after", 32'(iou), 32'd0);
        do_op("after_abort", 0, 0, 10, 10, 5, 0, 15, 10, 10, 10, 10, 10);
        repeat (25) @(posedge clk);

        // Randomized boxes, mostly consistent with their widths/heights.
        for (int i = 0; i < 40; i++) begin
            kx0 = $urandom_range(0, 1700);
            ky0 = $urandom_range(0, 1700);
            wk  = $urandom_range(0, 255);
            hk  = $urandom_range(0, 255);
            kx1 = kx0 + wk;
            ky1 = ky0 + hk;
            hx0 = imax(0, kx0 + int'($urandom_range(0, 80)) - 40);
            hy0 = imax(0, ky0 + int'($urandom_range(0, 80)) - 40);
            wh  = $urandom_range(0, 255);
            hh  = $urandom_range(0, 255);
            hx1 = hx0 + wh;
            hy1 = hy0 + hh;
            if (i % 7 == 0) begin
                hx0 = kx0; hy0 = ky0; hx1 = kx1; hy1 = ky1; wh = wk; hh = hk;
            end
            if (i % 5 == 4) begin
                wk = $urandom_range(0, 255);
                hk = $urandom_range(0, 255);
                wh = $urandom_range(0, 255);
                hh = $urandom_range(0, 255);
            end
            do_op($sformatf("rand%0d", i), kx0, ky0, kx1, ky1, hx0, hy0, hx1, hy1, wk, hk, wh, hh);
            repeat (25 + $urandom_range(0, 3)) @(posedge clk);
        end

        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
